// File: rtl/scv_pkg.sv
// Shared types and constants for the SCV cartridge memory arbiter.
//   arb_state_t : arbiter sequencer states
//   grant_t     : identifies which requester owned the last memory slot
//   CART_AW     : cartridge address width (128 KiB space)
//   CART_MIN_MASK : smallest mirror mask ever produced (4 KiB image)
package scv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DLW,
        CPUW,
        CPURD
    } arb_state_t;

    typedef enum logic {
        GR_DL,
        GR_CPU
    } grant_t;

    localparam int CART_AW       = 17;
    localparam int CART_MIN_MASK = 'h0FFF;

endpackage

// File: rtl/cart_mem_arb_size_track.sv
// Tracks the highest address written while a download session is open and,
// when the session closes, turns it into a power-of-two mirror mask.
// Ports:
//   clk, srst   : clock and synchronous active-high reset
//   dl_active   : download session open
//   upd         : a download byte is being written inside a session this cycle
//   upd_addr    : address of that byte
//   size_mask   : mirror mask (all ones until the first session closes)
module cart_size_track
    import scv_pkg::*;
#(
    parameter int AW = CART_AW
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          dl_active,
    input  logic          upd,
    input  logic [AW-1:0] upd_addr,
    output logic [AW-1:0] size_mask
);

    localparam logic [AW-1:0] MIN_MASK = AW'(CART_MIN_MASK);

    logic [AW-1:0] max_addr_q, max_addr_d;
    logic [AW-1:0] mask_q, mask_d;
    logic          dl_active_q, dl_active_d;
    logic [AW-1:0] round_up;

    // Bit gi of the rounded mask is set when any bit at or above gi is set in
    // max_addr: that is exactly the smallest 2^n-1 that covers max_addr.
    generate
        for (genvar gi = 0; gi < AW; gi++) begin : g_round
            assign round_up[gi] = (|max_addr_q[AW-1:gi]) | MIN_MASK[gi];
        end
    endgenerate

    always_comb begin
        max_addr_d  = max_addr_q;
        mask_d      = mask_q;
        dl_active_d = dl_active;
        if (dl_active && !dl_active_q) begin
            max_addr_d = '0;
        end
        // Compare against the possibly-cleared value so a byte landing on the
        // rising edge of a session is still counted.
        if (upd && (upd_addr > max_addr_d)) begin
            max_addr_d = upd_addr;
        end
        if (!dl_active && dl_active_q) begin
            mask_d = round_up;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            max_addr_q  <= '0;
            mask_q      <= '1;
            dl_active_q <= 1'b0;
        end else begin
            max_addr_q  <= max_addr_d;
            mask_q      <= mask_d;
            dl_active_q <= dl_active_d;
        end
    end

    assign size_mask = mask_q;

endmodule

// File: rtl/cart_mem_arb.sv
// Arbitrates the single-port cartridge RAM between the ROM download stream
// and the SCV CPU bus, one access at a time.
// Ports:
//   CLK, RST                 : clock, synchronous active-high reset
//   DL_ACTIVE/VALID/ADDR/DATA: download session flag and write request
//   DL_READY                 : download byte written this cycle
//   CPU_REQ/WE/ADDR/DIN      : CPU access request (level, held until ACK)
//   CPU_DOUT, CPU_ACK        : read data and one-cycle completion pulse
//   MEM_ADDR/WDATA/WE/RDATA  : synchronous RAM port (RD_LAT read latency)
//   SIZE_MASK                : current mirror mask
// A CPU read occupies CPURD for RD_LAT+1 cycles: the address is presented
// for RD_LAT cycles and the ACK cycle is the one in which MEM_RDATA is valid.
module cart_mem_arb
    import scv_pkg::*;
#(
    parameter int AW        = CART_AW,
    parameter int DW        = 8,
    parameter int RD_LAT    = 1,
    parameter int SRAM_BASE = 'h1E000
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          DL_ACTIVE,
    input  logic          DL_VALID,
    input  logic [AW-1:0] DL_ADDR,
    input  logic [DW-1:0] DL_DATA,
    output logic          DL_READY,
    input  logic          CPU_REQ,
    input  logic          CPU_WE,
    input  logic [AW-1:0] CPU_ADDR,
    input  logic [DW-1:0] CPU_DIN,
    output logic [DW-1:0] CPU_DOUT,
    output logic          CPU_ACK,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    output logic          MEM_WE,
    input  logic [DW-1:0] MEM_RDATA,
    output logic [AW-1:0] SIZE_MASK
);

    localparam logic [AW-1:0] SRAM_BASE_A = AW'(SRAM_BASE);
    localparam logic [1:0]    LAT_LAST    = 2'(RD_LAT);
    localparam logic [1:0]    LAT_PRE     = 2'(RD_LAT - 1);

    arb_state_t    state_q, state_d;
    grant_t        last_grant_q, last_grant_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          dl_ready_q, dl_ready_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          rd_ack_q, rd_ack_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] dout_q, dout_d;

    logic [AW-1:0] size_mask;
    logic [AW-1:0] eff_addr;
    logic          cpu_elig;
    logic          grant_dl;
    logic          size_upd;

    assign size_upd = (state_q == DLW) && DL_ACTIVE;

    cart_size_track #(.AW(AW)) u_size_track (
        .clk      (CLK),
        .srst     (RST),
        .dl_active(DL_ACTIVE),
        .upd      (size_upd),
        .upd_addr (mem_addr_q),
        .size_mask(size_mask)
    );

    // SRAM window sits above the ROM image and is never mirrored.
    assign eff_addr = (CPU_ADDR >= SRAM_BASE_A) ? CPU_ADDR : (CPU_ADDR & size_mask);

    // The CPU is locked out for the whole download session.
    assign cpu_elig = CPU_REQ && !DL_ACTIVE;
    assign grant_dl = DL_VALID && (!cpu_elig || (last_grant_q == GR_CPU));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        dl_ready_d   = 1'b0;
        cpu_ack_d    = 1'b0;
        rd_ack_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        dout_d       = rd_ack_q ? MEM_RDATA : dout_q;
        unique case (state_q)
            IDLE: begin
                if (grant_dl) begin
                    state_d      = DLW;
                    last_grant_d = GR_DL;
                    dl_ready_d   = 1'b1;
                    mem_we_d     = 1'b1;
                    mem_addr_d   = DL_ADDR;
                    mem_wdata_d  = DL_DATA;
                end else if (cpu_elig) begin
                    last_grant_d = GR_CPU;
                    mem_addr_d   = eff_addr;
                    if (CPU_WE) begin
                        state_d     = CPUW;
                        cpu_ack_d   = 1'b1;
                        mem_we_d    = (eff_addr >= SRAM_BASE_A);
                        mem_wdata_d = CPU_DIN;
                    end else begin
                        state_d = CPURD;
                        cnt_d   = '0;
                    end
                end
            end
            DLW, CPUW: begin
                state_d = IDLE;
            end
            CPURD: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                    // Register the ACK so it lands in the cycle the data arrives.
                    if (cnt_q == LAT_PRE) begin
                        cpu_ack_d = 1'b1;
                        rd_ack_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            last_grant_q <= GR_CPU;
            cnt_q        <= '0;
            dl_ready_q   <= 1'b0;
            cpu_ack_q    <= 1'b0;
            rd_ack_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            dout_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            dl_ready_q   <= dl_ready_d;
            cpu_ack_q    <= cpu_ack_d;
            rd_ack_q     <= rd_ack_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            dout_q       <= dout_d;
        end
    end

    assign DL_READY  = dl_ready_q;
    assign CPU_ACK   = cpu_ack_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    // Read data passes straight through in the ACK cycle, then is held.
    assign CPU_DOUT  = rd_ack_q ? MEM_RDATA : dout_q;
    assign SIZE_MASK = size_mask;

endmodule

// File: tb/tb_cart_mem_arb.sv
module tb_cart_mem_arb;

    localparam int AW        = 17;
    localparam int DW        = 8;
    localparam int RD_LAT    = 2;
    localparam int SRAM_BASE = 'h1E000;
    localparam int MEMSZ     = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          DL_ACTIVE = 1'b0;
    logic          DL_VALID = 1'b0;
    logic [AW-1:0] DL_ADDR = '0;
    logic [DW-1:0] DL_DATA = '0;
    logic          DL_READY;
    logic          CPU_REQ = 1'b0;
    logic          CPU_WE = 1'b0;
    logic [AW-1:0] CPU_ADDR = '0;
    logic [DW-1:0] CPU_DIN = '0;
    logic [DW-1:0] CPU_DOUT;
    logic          CPU_ACK;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic          MEM_WE;
    logic [DW-1:0] MEM_RDATA;
    logic [AW-1:0] SIZE_MASK;

    cart_mem_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .SRAM_BASE(SRAM_BASE)) dut (
        .CLK(CLK), .RST(RST),
        .DL_ACTIVE(DL_ACTIVE), .DL_VALID(DL_VALID), .DL_ADDR(DL_ADDR), .DL_DATA(DL_DATA),
        .DL_READY(DL_READY),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
        .CPU_DOUT(CPU_DOUT), .CPU_ACK(CPU_ACK),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE), .MEM_RDATA(MEM_RDATA),
        .SIZE_MASK(SIZE_MASK)
    );

    always #5 CLK = ~CLK;

    // Synchronous RAM with an RD_LAT-stage read pipeline.
    logic [DW-1:0] mem [0:MEMSZ-1];
    logic [DW-1:0] rd_pipe [0:2];
    always @(posedge CLK) begin
        if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
        rd_pipe[0] <= mem[MEM_ADDR];
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
    end
    assign MEM_RDATA = rd_pipe[RD_LAT-1];

    int cyc = 0;
    int ack_cnt = 0;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (CPU_ACK) ack_cnt <= ack_cnt + 1;

    // Reference model state
    logic [DW-1:0] exp_mem [int];
    logic [AW-1:0] model_mask = '1;
    int            model_max = 0;

    int total = 0;
    int bad = 0;
    int dl_err = 0;
    int dl_gap_err = 0;
    int prev_ready = -1;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [AW-1:0] exp_ma;
        bit            exp_we;
    } vec_t;
    vec_t vt [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int roundup(input int m);
        int r = 'hFFF;
        while (r < m) r = r * 2 + 1;
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic dl_byte(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got = 0;
        DL_VALID = 1'b1; DL_ADDR = a; DL_DATA = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (DL_READY) begin
                got = 1;
                if (!(MEM_WE && MEM_ADDR == a && MEM_WDATA == d)) dl_err++;
                if (prev_ready >= 0 && (cyc - prev_ready) != 2) dl_gap_err++;
                prev_ready = cyc;
                break;
            end
        end
        if (!got) dl_err++;
        tick();
        DL_VALID = 1'b0;
        exp_mem[int'(a)] = d;
        if (DL_ACTIVE && int'(a) > model_max) model_max = int'(a);
    endtask

    task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int lat, output logic [AW-1:0] ma, output logic mwe,
                          output logic [DW-1:0] dout);
        CPU_REQ = 1'b1; CPU_WE = we; CPU_ADDR = a; CPU_DIN = d;
        lat = -1; ma = '0; mwe = 1'b0; dout = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (CPU_ACK) begin
                lat = i; ma = MEM_ADDR; mwe = MEM_WE; dout = CPU_DOUT;
                break;
            end
        end
        tick();
        CPU_REQ = 1'b0; CPU_WE = 1'b0;
    endtask

    // Checks one CPU access against the mirror / write-protect rules.
    task automatic cpu_check(input string tag, input bit we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
        int lat; logic [AW-1:0] ma; logic mwe; logic [DW-1:0] dout;
        int eff;
        bit wr_ok;
        eff = (int'(a) >= SRAM_BASE) ? int'(a) : int'(a & model_mask);
        wr_ok = (eff >= SRAM_BASE);
        cpu_op(we, a, d, lat, ma, mwe, dout);
        chk({tag, "_lat"}, 32'(lat), we ? 32'd1 : 32'(1 + RD_LAT));
        if (!we || wr_ok) chk({tag, "_addr"}, 32'(ma), 32'(eff));
        if (we) begin
            chk({tag, "_we"}, 32'(mwe), 32'(wr_ok));
            if (wr_ok) exp_mem[eff] = d;
        end else if (exp_mem.exists(eff)) begin
            chk({tag, "_dout"}, 32'(dout), 32'(exp_mem[eff]));
        end
        $display("cpu %s we=%0d addr=%05h eff=%05h lat=%0d dout=%02h", tag, we, a, eff, lat, dout);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        DL_ACTIVE = 1'b0; DL_VALID = 1'b0; CPU_REQ = 1'b0; CPU_WE = 1'b0;
        tick(); tick();
        RST = 1'b0;
        model_mask = '1;
        model_max = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat; logic [AW-1:0] ma; logic mwe; logic [DW-1:0] dout;
        int err;
        int ev [$];
        int a0;

        vt[0] = '{0, 17'h06005, 8'h00, 17'h00005, 0};
        vt[1] = '{1, 17'h00100, 8'h55, 17'h00100, 0};
        vt[2] = '{0, 17'h00100, 8'h00, 17'h00100, 0};
        vt[3] = '{1, 17'h1E010, 8'hAA, 17'h1E010, 1};
        vt[4] = '{0, 17'h1E010, 8'h00, 17'h1E010, 0};
        vt[5] = '{1, 17'h1FFFF, 8'h5A, 17'h1FFFF, 1};
        vt[6] = '{0, 17'h1FFFF, 8'h00, 17'h1FFFF, 0};
        vt[7] = '{0, 17'h1DFFF, 8'h00, 17'h01FFF, 0};
        vt[8] = '{1, 17'h1DFFF, 8'h11, 17'h01FFF, 0};
        vt[9] = '{0, 17'h03ABC, 8'h00, 17'h01ABC, 0};

        // Reset state
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_dl_ready", 32'(DL_READY), 32'd0);
        chk("rst_cpu_ack", 32'(CPU_ACK), 32'd0);
        chk("rst_mem_we", 32'(MEM_WE), 32'd0);
        chk("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
        chk("rst_mem_wdata", 32'(MEM_WDATA), 32'd0);
        chk("rst_cpu_dout", 32'(CPU_DOUT), 32'd0);
        chk("rst_size_mask", 32'(SIZE_MASK), 32'h1FFFF);
        do_reset();

        // 1: full 8 KiB download
        DL_ACTIVE = 1'b1;
        dl_err = 0; dl_gap_err = 0; prev_ready = -1;
        for (int i = 0; i < 'h2000; i++) dl_byte(AW'(i), DW'($urandom));
        DL_ACTIVE = 1'b0;
        tick(); tick(); tick();
        model_mask = AW'(roundup(model_max));
        $display("download done max=%05h mask=%05h", model_max, SIZE_MASK);
        chk("dl_write", 32'(dl_err), 32'd0);
        chk("dl_gap", 32'(dl_gap_err), 32'd0);
        chk("dl_size_mask", 32'(SIZE_MASK), 32'(model_mask));
        err = 0;
        for (int i = 0; i < 'h2000; i++) if (mem[i] !== exp_mem[i]) err++;
        chk("dl_image", 32'(err), 32'd0);

        // 2/3: table of CPU accesses with explicit expected addresses
        for (int i = 0; i < 10; i++) begin
            cpu_op(vt[i].we, vt[i].addr, vt[i].din, lat, ma, mwe, dout);
            chk($sformatf("vec%0d_lat", i), 32'(lat), vt[i].we ? 32'd1 : 32'(1 + RD_LAT));
            if (!(vt[i].we && !vt[i].exp_we))
                chk($sformatf("vec%0d_addr", i), 32'(ma), 32'(vt[i].exp_ma));
            if (vt[i].we) begin
                chk($sformatf("vec%0d_we", i), 32'(mwe), 32'(vt[i].exp_we));
                if (vt[i].exp_we) exp_mem[int'(vt[i].exp_ma)] = vt[i].din;
            end else if (exp_mem.exists(int'(vt[i].exp_ma))) begin
                chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(exp_mem[int'(vt[i].exp_ma)]));
            end
            $display("vec %0d we=%0d addr=%05h mem_addr=%05h lat=%0d dout=%02h",
                     i, vt[i].we, vt[i].addr, ma, lat, dout);
        end

        // Random CPU traffic and stray download writes against the model
        dl_err = 0;
        for (int n = 0; n < 150; n++) begin
            int r = $urandom_range(0, 9);
            if (r < 2) begin
                a0 = $urandom_range(0, MEMSZ - 1);
                dl_byte(AW'(a0), DW'($urandom));
                $display("stray dl addr=%05h", a0);
            end else begin
                a0 = (r < 6) ? $urandom_range(0, SRAM_BASE - 1) : $urandom_range(SRAM_BASE, MEMSZ - 1);
                cpu_check($sformatf("rnd%0d", n), bit'($urandom_range(0, 1)), AW'(a0), DW'($urandom));
            end
        end
        chk("stray_dl_write", 32'(dl_err), 32'd0);

        // 4: continuous contention after reset alternates DL, CPU, ...
        do_reset();
        DL_VALID = 1'b1; DL_ADDR = 17'h1E100; DL_DATA = 8'h3C;
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 17'h1E100;
        exp_mem['h1E100] = 8'h3C;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (DL_READY) ev.push_back(0);
            if (CPU_ACK) begin
                ev.push_back(1);
                chk("rr_dout", 32'(CPU_DOUT), 32'h3C);
            end
        end
        tick();
        DL_VALID = 1'b0; CPU_REQ = 1'b0;
        chk("rr_events", 32'(ev.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < ev.size(); i++) begin
            chk($sformatf("rr_grant%0d", i), 32'(ev[i]), 32'(i % 2));
            $display("rr event %0d grant=%s", i, ev[i] ? "CPU" : "DL");
        end
        tick(); tick();

        // 5: CPU locked out for a whole session, served right after it
        DL_ACTIVE = 1'b1;
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 17'h1E100;
        a0 = ack_cnt;
        dl_byte(17'h00000, 8'h01);
        dl_byte(17'h00001, 8'h02);
        dl_byte(17'h04321, 8'h03);
        dl_byte(17'h00002, 8'h04);
        repeat (10) tick();
        chk("session_no_ack", 32'(ack_cnt - a0), 32'd0);
        DL_ACTIVE = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (CPU_ACK) begin
                lat = i;
                chk("post_session_dout", 32'(CPU_DOUT), 32'h3C);
                break;
            end
        end
        tick();
        CPU_REQ = 1'b0;
        chk("post_session_lat_ok", 32'(lat >= 0 && lat <= 1 + RD_LAT), 32'd1);
        $display("session ack latency=%0d", lat);
        tick(); tick();
        model_mask = AW'(roundup(model_max));
        chk("session_mask", 32'(SIZE_MASK), 32'(model_mask));

        // 6: reset during the second CPURD cycle aborts the read
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 17'h00001;
        tick();
        tick();
        RST = 1'b1; CPU_REQ = 1'b0;
        @(negedge CLK);
        chk("abort_ack_c2", 32'(CPU_ACK), 32'd0);
        tick();
        @(negedge CLK);
        chk("abort_ack", 32'(CPU_ACK), 32'd0);
        chk("abort_mem_we", 32'(MEM_WE), 32'd0);
        chk("abort_mem_addr", 32'(MEM_ADDR), 32'd0);
        chk("abort_dout", 32'(CPU_DOUT), 32'd0);
        chk("abort_dl_ready", 32'(DL_READY), 32'd0);
        chk("abort_mask", 32'(SIZE_MASK), 32'h1FFFF);
        tick();
        RST = 1'b0;
        model_mask = '1;
        model_max = 0;
        tick();
        cpu_check("after_abort", 1'b0, 17'h1E100, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
